// File: rtl/dual_channel_mem_slave.sv
// Word-addressed local memory behind independent write and read request channels.
// Each channel accepts one request at a time, waits a fixed latency, then pulses a
// one-cycle response. Requests outside [BASE_ADDR, BASE_ADDR+DEPTH) are misses.
module dual_channel_mem_slave #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH       = 64,
  parameter int                WR_LAT      = 2,
  parameter int                RD_LAT      = 2,
  parameter int                ERR_ON_MISS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                w_resp_valid,
  output logic [1:0]          w_resp,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_resp_valid,
  output logic [1:0]          r_resp
);

  localparam int              SW       = DATA_W / 8;
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so BASE_ADDR+DEPTH never wraps to a small value.
  localparam logic [ADDR_W:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI_BOUND = LO_BOUND + (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WR_INIT  = 4'(WR_LAT - 1);
  localparam logic [3:0]      RD_INIT  = 4'(RD_LAT - 1);
  localparam logic [1:0]      MISS_RESP = (ERR_ON_MISS != 0) ? 2'b10 : 2'b00;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_wr_state, w_wr_state_next;
  state_t            r_rd_state, w_rd_state_next;
  logic [3:0]        r_wr_cnt, r_rd_cnt;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [SW-1:0]     r_wr_strb;
  logic              r_wr_hit, r_rd_hit;
  logic              r_wr_ready, r_rd_ready;
  logic              r_wr_resp_valid, r_rd_resp_valid;
  logic [1:0]        r_wr_resp, r_rd_resp;
  logic [DATA_W-1:0] r_rd_word;
  logic              r_rd_word_ok;

  logic              w_wr_accept, w_rd_accept;
  logic              w_wr_done, w_rd_done;
  logic              w_wr_hit_in, w_rd_hit_in;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;

  assign w_wr_accept = w_valid && r_wr_ready;
  assign w_rd_accept = r_valid && r_rd_ready;
  assign w_wr_done   = (r_wr_state == ST_WAIT) && (r_wr_cnt == 4'd0);
  assign w_rd_done   = (r_rd_state == ST_WAIT) && (r_rd_cnt == 4'd0);
  assign w_wr_hit_in = ({1'b0, w_addr} >= LO_BOUND) && ({1'b0, w_addr} < HI_BOUND);
  assign w_rd_hit_in = ({1'b0, r_addr} >= LO_BOUND) && ({1'b0, r_addr} < HI_BOUND);
  assign w_wr_idx    = IDX_W'(r_wr_addr - BASE_ADDR);
  assign w_rd_idx    = IDX_W'(r_rd_addr - BASE_ADDR);

  assign w_ready      = r_wr_ready;
  assign r_ready      = r_rd_ready;
  assign w_resp_valid = r_wr_resp_valid;
  assign w_resp       = r_wr_resp;
  assign r_resp_valid = r_rd_resp_valid;
  assign r_resp       = r_rd_resp;
  // A miss (or no read since reset) presents zero; a hit presents the stored word.
  assign r_data       = r_rd_word_ok ? r_rd_word : '0;

  // Write channel next-state: accept -> count down latency -> one response cycle.
  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      ST_IDLE: if (w_wr_accept) w_wr_state_next = ST_WAIT;
      ST_WAIT: if (r_wr_cnt == 4'd0) w_wr_state_next = ST_RESP;
      ST_RESP: w_wr_state_next = ST_IDLE;
      default: w_wr_state_next = ST_IDLE;
    endcase
  end

  // Read channel next-state, same shape as the write channel.
  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      ST_IDLE: if (w_rd_accept) w_rd_state_next = ST_WAIT;
      ST_WAIT: if (r_rd_cnt == 4'd0) w_rd_state_next = ST_RESP;
      ST_RESP: w_rd_state_next = ST_IDLE;
      default: w_rd_state_next = ST_IDLE;
    endcase
  end

  // Write channel state, request capture, latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state      <= ST_IDLE;
      r_wr_ready      <= 1'b0;
      r_wr_cnt        <= 4'd0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_wr_strb       <= '0;
      r_wr_hit        <= 1'b0;
      r_wr_resp_valid <= 1'b0;
      r_wr_resp       <= 2'b00;
    end else begin
      r_wr_state      <= w_wr_state_next;
      r_wr_ready      <= (w_wr_state_next == ST_IDLE);
      r_wr_resp_valid <= w_wr_done;
      r_wr_resp       <= (w_wr_done && !r_wr_hit) ? MISS_RESP : 2'b00;
      if (w_wr_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
        r_wr_strb <= w_strb;
        r_wr_hit  <= w_wr_hit_in;
        r_wr_cnt  <= WR_INIT;
      end else if (r_wr_state == ST_WAIT && r_wr_cnt != 4'd0) begin
        r_wr_cnt <= r_wr_cnt - 4'd1;
      end
    end
  end

  // Read channel state, request capture, latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state      <= ST_IDLE;
      r_rd_ready      <= 1'b0;
      r_rd_cnt        <= 4'd0;
      r_rd_addr       <= '0;
      r_rd_hit        <= 1'b0;
      r_rd_resp_valid <= 1'b0;
      r_rd_resp       <= 2'b00;
      r_rd_word_ok    <= 1'b0;
    end else begin
      r_rd_state      <= w_rd_state_next;
      r_rd_ready      <= (w_rd_state_next == ST_IDLE);
      r_rd_resp_valid <= w_rd_done;
      r_rd_resp       <= (w_rd_done && !r_rd_hit) ? MISS_RESP : 2'b00;
      if (w_rd_done) r_rd_word_ok <= r_rd_hit;
      if (w_rd_accept) begin
        r_rd_addr <= r_addr;
        r_rd_hit  <= w_rd_hit_in;
        r_rd_cnt  <= RD_INIT;
      end else if (r_rd_state == ST_WAIT && r_rd_cnt != 4'd0) begin
        r_rd_cnt <= r_rd_cnt - 4'd1;
      end
    end
  end

  // Memory array: byte-masked write and registered read, both on the completion edge.
  // A same-edge read of the written word sees the old contents.
  always_ff @(posedge clk) begin
    if (w_wr_done && r_wr_hit) begin
      for (int i = 0; i < SW; i++) begin
        if (r_wr_strb[i]) r_mem[w_wr_idx][i*8 +: 8] <= r_wr_data[i*8 +: 8];
      end
    end
    if (w_rd_done && r_rd_hit) r_rd_word <= r_mem[w_rd_idx];
  end

endmodule

// File: tb/tb_dual_channel_mem_slave.sv
// Directed bench: instance 0 (BASE 0x40, WR_LAT 2, RD_LAT 3, SLVERR on miss) and
// instance 1 (BASE 0x40, WR_LAT 2, RD_LAT 2, OKAY on miss), driven by a vector table
// plus hand sequences for same-edge completion and reset mid-transaction.
module tb_dual_channel_mem_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        w_valid[2], w_ready[2], w_resp_valid[2];
  logic [7:0]  w_addr[2];
  logic [31:0] w_data[2];
  logic [3:0]  w_strb[2];
  logic [1:0]  w_resp[2];
  logic        r_valid[2], r_ready[2], r_resp_valid[2];
  logic [7:0]  r_addr[2];
  logic [31:0] r_data[2];
  logic [1:0]  r_resp[2];

  dual_channel_mem_slave #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(8'h40), .DEPTH(64),
    .WR_LAT(2), .RD_LAT(3), .ERR_ON_MISS(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
    .w_strb(w_strb[0]), .w_resp_valid(w_resp_valid[0]), .w_resp(w_resp[0]),
    .r_valid(r_valid[0]), .r_ready(r_ready[0]), .r_addr(r_addr[0]), .r_data(r_data[0]),
    .r_resp_valid(r_resp_valid[0]), .r_resp(r_resp[0]));

  dual_channel_mem_slave #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(8'h40), .DEPTH(64),
    .WR_LAT(2), .RD_LAT(2), .ERR_ON_MISS(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
    .w_strb(w_strb[1]), .w_resp_valid(w_resp_valid[1]), .w_resp(w_resp[1]),
    .r_valid(r_valid[1]), .r_ready(r_ready[1]), .r_addr(r_addr[1]), .r_data(r_data[1]),
    .r_resp_valid(r_resp_valid[1]), .r_resp(r_resp[1]));

  typedef struct {
    int          k;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] edata;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int k, input bit wr);
    if (wr) return 2;
    return (k == 0) ? 3 : 2;
  endfunction

  task automatic do_txn(input int k, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [1:0] eresp, input logic [31:0] edata, input string name);
    int  n;
    bit  got;
    n = 0;
    while (!(wr ? w_ready[k] : r_ready[k]) && n < 20) begin
      tick();
      n++;
    end
    chk({name, " ready"}, 32'(wr ? w_ready[k] : r_ready[k]), 32'd1);
    if (wr) begin
      w_valid[k] = 1'b1; w_addr[k] = addr; w_data[k] = data; w_strb[k] = strb;
    end else begin
      r_valid[k] = 1'b1; r_addr[k] = addr;
    end
    tick();
    if (wr) w_valid[k] = 1'b0;
    else    r_valid[k] = 1'b0;
    chk({name, " ready_low"}, 32'(wr ? w_ready[k] : r_ready[k]), 32'd0);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = wr ? w_resp_valid[k] : r_resp_valid[k];
    end
    chk({name, " latency"}, 32'(n), 32'(lat_of(k, wr)));
    chk({name, " resp"}, 32'(wr ? w_resp[k] : r_resp[k]), 32'(eresp));
    if (!wr) chk({name, " rdata"}, r_data[k], edata);
    tick();
    chk({name, " resp_valid_drop"}, 32'(wr ? w_resp_valid[k] : r_resp_valid[k]), 32'd0);
    chk({name, " resp_clear"}, 32'(wr ? w_resp[k] : r_resp[k]), 32'd0);
    chk({name, " ready_back"}, 32'(wr ? w_ready[k] : r_ready[k]), 32'd1);
    if (!wr) chk({name, " rdata_hold"}, r_data[k], edata);
    $display("txn %s: inst=%0d %s addr=%h data=%h strb=%h resp=%b rdata=%h", name, k,
             wr ? "WR" : "RD", addr, data, strb, wr ? w_resp[k] : r_resp[k], r_data[k]);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      w_valid[k] = 1'b0; w_addr[k] = '0; w_data[k] = '0; w_strb[k] = '0;
      r_valid[k] = 1'b0; r_addr[k] = '0;
    end

    vecs[0]  = '{0, 1'b1, 8'h45, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{0, 1'b0, 8'h45, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{0, 1'b1, 8'h45, 32'h11223344, 4'h5, 2'b00, 32'h0};
    vecs[3]  = '{0, 1'b0, 8'h45, 32'h0,        4'h0, 2'b00, 32'hDE22BE44};
    vecs[4]  = '{0, 1'b1, 8'h7F, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    vecs[5]  = '{0, 1'b1, 8'h40, 32'h01020304, 4'hF, 2'b00, 32'h0};
    vecs[6]  = '{0, 1'b1, 8'h3F, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{0, 1'b1, 8'h80, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vecs[8]  = '{0, 1'b0, 8'h7F, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vecs[9]  = '{0, 1'b0, 8'h40, 32'h0,        4'h0, 2'b00, 32'h01020304};
    vecs[10] = '{0, 1'b0, 8'h80, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[11] = '{0, 1'b0, 8'h3F, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[12] = '{0, 1'b1, 8'h46, 32'h12345678, 4'hF, 2'b00, 32'h0};
    vecs[13] = '{1, 1'b1, 8'h7F, 32'h00000077, 4'hF, 2'b00, 32'h0};
    vecs[14] = '{1, 1'b1, 8'h3F, 32'h55555555, 4'hF, 2'b00, 32'h0};
    vecs[15] = '{1, 1'b1, 8'h80, 32'h55555555, 4'hF, 2'b00, 32'h0};
    vecs[16] = '{1, 1'b0, 8'h7F, 32'h0,        4'h0, 2'b00, 32'h00000077};
    vecs[17] = '{1, 1'b0, 8'h80, 32'h0,        4'h0, 2'b00, 32'h0};
    vecs[18] = '{1, 1'b1, 8'h50, 32'h00000000, 4'hF, 2'b00, 32'h0};

    // Reset state, then ready rises only at the first edge after release.
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst w_ready%0d", k), 32'(w_ready[k]), 32'd0);
      chk($sformatf("rst r_ready%0d", k), 32'(r_ready[k]), 32'd0);
      chk($sformatf("rst w_resp_valid%0d", k), 32'(w_resp_valid[k]), 32'd0);
      chk($sformatf("rst r_resp_valid%0d", k), 32'(r_resp_valid[k]), 32'd0);
      chk($sformatf("rst r_data%0d", k), r_data[k], 32'd0);
      chk($sformatf("rst resp%0d", k), 32'({w_resp[k], r_resp[k]}), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("release ready_before_edge", 32'(w_ready[0]), 32'd0);
    tick();
    chk("release w_ready_after_edge", 32'(w_ready[0]), 32'd1);
    chk("release r_ready_after_edge", 32'(r_ready[1]), 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_txn(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
             vecs[i].resp, vecs[i].edata, $sformatf("v%0d", i));
    end

    // Write and read of word 0x50 accepted together: read must see the old zero.
    w_valid[1] = 1'b1; w_addr[1] = 8'h50; w_data[1] = 32'hA5A5A5A5; w_strb[1] = 4'hF;
    r_valid[1] = 1'b1; r_addr[1] = 8'h50;
    tick();
    w_valid[1] = 1'b0; r_valid[1] = 1'b0;
    tick();
    chk("simul early_resp", 32'({w_resp_valid[1], r_resp_valid[1]}), 32'd0);
    tick();
    chk("simul both_resp", 32'({w_resp_valid[1], r_resp_valid[1]}), 32'd3);
    chk("simul old_data", r_data[1], 32'h0);
    $display("txn simul: inst=1 WR+RD addr=50 rdata=%h", r_data[1]);
    tick();
    do_txn(1, 1'b0, 8'h50, 32'h0, 4'h0, 2'b00, 32'hA5A5A5A5, "simul_reread");

    // Reset one cycle after a write accept: no response, no commit.
    w_valid[0] = 1'b1; w_addr[0] = 8'h46; w_data[0] = 32'hFFFFFFFF; w_strb[0] = 4'hF;
    tick();
    w_valid[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort ready_in_reset", 32'(w_ready[0]), 32'd0);
    tick();
    chk("abort no_resp1", 32'(w_resp_valid[0]), 32'd0);
    tick();
    chk("abort no_resp2", 32'(w_resp_valid[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort ready_before_edge", 32'(w_ready[0]), 32'd0);
    tick();
    chk("abort ready_after_edge", 32'(w_ready[0]), 32'd1);
    $display("txn abort: inst=0 WR addr=46 aborted by reset");
    do_txn(0, 1'b0, 8'h46, 32'h0, 4'h0, 2'b00, 32'h12345678, "abort_readback");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_channel_mem_slave.md
Name: dual_channel_mem_slave

Overview:
- Parametrised successor to the single-region bus slave: a local memory with independent write and read channels.
- Adds explicit valid/ready request handshakes and a separate one-cycle response strobe per channel.
- Adds configurable fixed latency, byte write strobes, and an error response for out-of-range addresses.
- Sits behind the bus manager/interconnect as one addressable region; multiple instances are tiled using different BASE_ADDR values.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- BASE_ADDR, 8'h00, first address of the region.
- DEPTH, 64, number of words; BASE_ADDR+DEPTH must be <= 2**ADDR_W.
- WR_LAT, 2, write latency in cycles (1..15).
- RD_LAT, 2, read latency in cycles (1..15).
- ERR_ON_MISS, 1, 1 = out-of-range access returns SLVERR; 0 = returns OKAY and is otherwise ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- w_valid  in  1  write request valid
- w_ready  out  1  write request accept
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- w_strb  in  DATA_W/8  byte enables
- w_resp_valid  out  1  write response strobe
- w_resp  out  2  00 OKAY, 10 SLVERR
- r_valid  in  1  read request valid
- r_ready  out  1  read request accept
- r_addr  in  ADDR_W  read address
- r_data  out  DATA_W  read data, valid with r_resp_valid
- r_resp_valid  out  1  read response strobe
- r_resp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Single clock clk; reset is asynchronous, active-low on rst_n.
- Reset values: w_ready=0, r_ready=0, w_resp_valid=0, r_resp_valid=0, w_resp=00, r_resp=00, r_data=0, both FSMs in IDLE. Memory contents are not reset.
- w_ready and r_ready are registered and rise at the first clk edge after rst_n deasserts.
- Each channel runs its own FSM with states IDLE, WAIT, RESP. The two channels are fully independent and may be busy concurrently.
- IDLE: ready=1. A handshake at edge N (valid && ready) does the following:
  - captures addr/data/strb;
  - computes the hit flag as BASE_ADDR <= addr < BASE_ADDR+DEPTH, compared at ADDR_W+1 bits so there is no wrap;
  - loads the counter with LAT-1;
  - goes to WAIT with ready=0.
- WAIT: decrements the counter each edge. When the counter is 0, goes to RESP at the next edge, which is edge N+LAT. The memory action occurs at that same edge:
  - write hit: each byte i with strb[i]=1 is updated; bytes with strb[i]=0 are unchanged;
  - read hit: r_data is loaded from mem[addr-BASE_ADDR].
- RESP: resp_valid=1 for exactly one cycle, between edge N+LAT and edge N+LAT+1, then returns to IDLE.
  - ready is 1 again from edge N+LAT+1.
  - The next accept is therefore possible at edge N+LAT+2 at the earliest.
  - Request-to-request throughput is one transaction per LAT+2 cycles.
- resp value is 00 on a hit. On a miss:
  - ERR_ON_MISS=1 gives 10; ERR_ON_MISS=0 gives 00;
  - a write miss never modifies memory;
  - a read miss drives r_data=0.
- r_data holds its value until the next read completes. resp returns to 00 when resp_valid drops.
- Simultaneous completion: a write and a read to the same word completing on the same edge -> the read returns the old data; the write takes effect afterwards.
- A write completing strictly before the read's completion edge is visible to the read.
- valid may drop without a handshake; no state change results. Inputs other than valid are ignored outside IDLE.
- Reset asserted mid-transaction aborts it: no response is issued, and a pending write is not committed.

Test Plan:
- Reset release, WR_LAT=2: write addr 8'h05, data 32'hDEADBEEF, strb 4'hF at edge N -> w_ready low at N; w_resp_valid=1, w_resp=00 in the cycle after N+2; w_ready high from N+3.
- Read back 8'h05 with RD_LAT=3 -> r_resp_valid pulses one cycle after edge N+3, r_data=32'hDEADBEEF, r_resp=00.
- Partial strobe: write 32'h11223344 with strb 4'b0101 over DEADBEEF, then read -> 32'hDE22BE44.
- BASE_ADDR=8'h40, DEPTH=64: write to 8'h3F and to 8'h80 -> w_resp=10, memory unchanged. Read 8'h80 -> r_resp=10, r_data=0. Repeat with ERR_ON_MISS=0 -> resp 00.
- WR_LAT=RD_LAT=2: accept a write of 32'hA5A5A5A5 and a read on the same edge to the same word holding 32'h0 -> the read returns 0. A second read then returns A5A5A5A5.
- Assert rst_n low one cycle after a write accept -> no w_resp_valid is issued, a subsequent read shows the old data, and ready is 0 until the first edge after release.
